// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the phase type used by the
// horizontal and vertical counters.
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int H_DISPLAY_640 = 640;
  localparam int H_FRONT_640   = 16;
  localparam int H_SYNC_640    = 96;
  localparam int H_BACK_640    = 48;

  localparam int V_DISPLAY_480 = 480;
  localparam int V_FRONT_480   = 10;
  localparam int V_SYNC_480    = 2;
  localparam int V_BACK_480    = 33;

  localparam int H_DISPLAY_1152 = 1152;
  localparam int H_FRONT_1152   = 64;
  localparam int H_SYNC_1152    = 128;
  localparam int H_BACK_1152    = 256;

  localparam int V_DISPLAY_864 = 864;
  localparam int V_FRONT_864   = 1;
  localparam int V_SYNC_864    = 3;
  localparam int V_BACK_864    = 32;

  typedef enum logic [1:0] {
    PH_DISPLAY,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

endpackage

// File: rtl/v_counter.sv
// Vertical timing stage: counts line_end strobes into a line index
// and registers the phase flags, vsync and frame_start from it.
`timescale 1ns/1ps
module v_counter
  import vga_timing_pkg::*;
#(
  parameter int V_DISPLAY    = V_DISPLAY_480,
  parameter int V_FRONT      = V_FRONT_480,
  parameter int V_SYNC       = V_SYNC_480,
  parameter int V_BACK       = V_BACK_480,
  parameter int LINE_W       = 10,
  parameter bit VSYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_end,
  input  logic              h_display,
  output logic              vsync,
  output logic              v_display,
  output logic              v_front_porch,
  output logic              v_sync_pulse,
  output logic              v_back_porch,
  output logic [LINE_W-1:0] v_line,
  output logic              frame_start,
  output logic              video_on
);

  localparam int TOTAL = V_DISPLAY + V_FRONT
                       + V_SYNC + V_BACK;

  localparam logic [LINE_W-1:0] LAST =
    LINE_W'(TOTAL - 1);
  localparam logic [LINE_W-1:0] FRONT_AT =
    LINE_W'(V_DISPLAY);
  localparam logic [LINE_W-1:0] SYNC_AT =
    LINE_W'(V_DISPLAY + V_FRONT);
  localparam logic [LINE_W-1:0] BACK_AT =
    LINE_W'(V_DISPLAY + V_FRONT + V_SYNC);

  phase_e            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [3:0]        flags_q, flags_d;
  logic              vsync_q, vsync_d;
  logic              fs_q, fs_d;

  always_comb begin
    line_d  = line_q;
    state_d = state_q;
    fs_d    = 1'b0;
    if (line_end) begin
      if (line_q == LAST) begin
        line_d = '0;
        fs_d   = 1'b1;
      end else begin
        line_d = line_q + LINE_W'(1);
      end
      // Phase follows the line the counter is moving to.
      if (line_d < FRONT_AT) begin
        state_d = PH_DISPLAY;
      end else if (line_d < SYNC_AT) begin
        state_d = PH_FRONT;
      end else if (line_d < BACK_AT) begin
        state_d = PH_SYNC;
      end else begin
        state_d = PH_BACK;
      end
    end
  end

  always_comb begin
    flags_d = 4'b0001;
    vsync_d = ~VSYNC_ACTIVE;
    unique case (state_d)
      PH_DISPLAY: flags_d = 4'b0001;
      PH_FRONT:   flags_d = 4'b0010;
      PH_SYNC: begin
        flags_d = 4'b0100;
        vsync_d = VSYNC_ACTIVE;
      end
      PH_BACK:    flags_d = 4'b1000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PH_DISPLAY;
      line_q  <= '0;
      flags_q <= 4'b0001;
      vsync_q <= ~VSYNC_ACTIVE;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      flags_q <= flags_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign v_display     = flags_q[0];
  assign v_front_porch = flags_q[1];
  assign v_sync_pulse  = flags_q[2];
  assign v_back_porch  = flags_q[3];
  assign v_line        = line_q;
  assign vsync         = vsync_q;
  assign frame_start   = fs_q;
  assign video_on      = h_display & flags_q[0];

endmodule

// File: tb/tb_v_counter.sv
// Randomized bench for v_counter: a line-number model drives
// per-cycle checks of a negative- and a positive-vsync instance.
`timescale 1ns/1ps
module tb_v_counter;

  localparam int TOTAL = 525;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_end;
  logic       h_display;

  logic       vs0, vd0, vf0, vp0, vb0, fs0, vo0;
  logic [9:0] vl0;
  logic       vs1, vd1, vf1, vp1, vb1, fs1, vo1;
  logic [9:0] vl1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit checking = 1'b0;
  int m_line = 0;
  bit m_fs = 1'b0;
  int fs_times[$];

  v_counter u_neg (
    .clk(clk), .reset(reset),
    .line_end(line_end), .h_display(h_display),
    .vsync(vs0), .v_display(vd0),
    .v_front_porch(vf0), .v_sync_pulse(vp0),
    .v_back_porch(vb0), .v_line(vl0),
    .frame_start(fs0), .video_on(vo0)
  );

  v_counter #(.VSYNC_ACTIVE(1'b1)) u_pos (
    .clk(clk), .reset(reset),
    .line_end(line_end), .h_display(h_display),
    .vsync(vs1), .v_display(vd1),
    .v_front_porch(vf1), .v_sync_pulse(vp1),
    .v_back_porch(vb1), .v_line(vl1),
    .frame_start(fs1), .video_on(vo1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // Reference: a line number that advances per line_end modulo TOTAL.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_line = 0;
      m_fs   = 1'b0;
    end else begin
      m_fs = line_end && (m_line == TOTAL - 1);
      if (line_end) m_line = (m_line + 1) % TOTAL;
    end
  end

  always @(negedge clk) begin
    bit disp, fr, sy, bk;
    if (checking) begin
      disp = m_line < 480;
      fr   = m_line >= 480 && m_line < 490;
      sy   = m_line >= 490 && m_line < 492;
      bk   = m_line >= 492;
      chk("v_line", vl0, m_line);
      chk("v_display", vd0, disp);
      chk("v_front_porch", vf0, fr);
      chk("v_sync_pulse", vp0, sy);
      chk("v_back_porch", vb0, bk);
      chk("vsync_neg", vs0, !sy);
      chk("frame_start", fs0, m_fs);
      chk("video_on", vo0, h_display && disp);
      chk("onehot", $countones({vd0, vf0, vp0, vb0}), 1);
      chk("vsync_pos", vs1, sy);
      chk("v_line_pos", vl1, m_line);
      chk("flags_pos", {vb1, vp1, vf1, vd1},
          {bk, sy, fr, disp});
      chk("frame_start_pos", fs1, m_fs);
      chk("video_on_pos", vo1, h_display && disp);
      if (fs0) fs_times.push_back(cyc);
    end
  end

  task automatic tick(bit le);
    line_end  = le;
    h_display = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic goto_line(int n);
    int guard = 0;
    while (m_line != n && guard < 2000) begin
      repeat ($urandom_range(0, 2)) tick(1'b0);
      tick(1'b1);
      guard++;
    end
    chk("goto_line_bound", m_line, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    line_end  = 1'b1;
    h_display = 1'b0;
    #2 checking = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_line", vl0, 0);
    chk("reset_disp", vd0, 1);
    chk("reset_front", vf0, 0);
    chk("reset_vsync_neg", vs0, 1);
    chk("reset_vsync_pos", vs1, 0);
    chk("reset_fs", fs0, 0);
    reset    = 1'b0;
    line_end = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("post_reset_hold", vl0, 0);

    goto_line(100);
    for (int i = 0; i < 8; i++) begin
      line_end  = 1'b0;
      h_display = i[0];
      #1;
      chk("video_on_l100", vo0, i[0]);
      @(posedge clk);
      #1;
    end

    goto_line(300);
    line_end = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midreset_line", vl0, 0);
    chk("midreset_disp", vd0, 1);
    chk("midreset_back", vb0, 0);
    chk("midreset_vsync", vs0, 1);
    tick(1'b1);
    tick(1'b1);
    chk("reset_with_line_end", vl0, 0);
    reset = 1'b0;
    tick(1'b1);
    chk("first_after_reset", vl0, 1);

    goto_line(478);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      chk("stuck_line", vl0, 479 + i);
      if (i == 1) begin
        chk("stuck_front", vf0, 1);
        chk("stuck_disp", vd0, 0);
      end
    end
    tick(1'b0);
    chk("stuck_hold", vl0, 483);

    goto_line(489);
    chk("vsync_l489", vs0, 1);
    tick(1'b1);
    chk("vsync_l490", vs0, 0);
    chk("vsync_pos_l490", vs1, 1);
    chk("sync_l490", vp0, 1);
    tick(1'b1);
    chk("vsync_l491", vs0, 0);
    tick(1'b1);
    chk("vsync_l492", vs0, 1);
    chk("back_l492", vb0, 1);

    goto_line(495);
    h_display = 1'b1;
    line_end  = 1'b0;
    #1;
    chk("video_on_l495", vo0, 0);
    @(posedge clk);
    #1;

    goto_line(524);
    tick(1'b1);
    chk("wrap_line", vl0, 0);
    chk("wrap_disp", vd0, 1);
    chk("wrap_fs", fs0, 1);
    tick(1'b0);
    chk("wrap_fs_clear", fs0, 0);

    fs_times.delete();
    for (int f = 0; f < 3 * TOTAL; f++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
    end
    chk("fs_count", fs_times.size(), 3);
    for (int k = 1; k < fs_times.size(); k++)
      chk("fs_period", fs_times[k] - fs_times[k-1], 3 * TOTAL);

    for (int r = 0; r < 1500; r++)
      tick(1'($urandom_range(0, 1)));

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
